// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32-style core: FETCH/DECODE/EXECUTE/MEM/WB with sticky trap.
// Outputs decode combinationally from the registered state and the IR opcode.
module multicycle_control #(
    parameter int MEM_HS  = 1,
    parameter int TRAP_EN = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             instr_read,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src_imm,
    output logic [1:0]       wb_sel,
    output logic             pc_sel,
    output logic             illegal_insn,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_TRAP    = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             ready;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI: is_legal = 1'b1;
            default:                                                 is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] wb_of(input logic [6:0] op);
        case (op)
            OP_LOAD: wb_of = 2'b01;
            OP_JAL:  wb_of = 2'b10;
            OP_LUI:  wb_of = 2'b11;
            default: wb_of = 2'b00;
        endcase
    endfunction

    // Without the handshake every memory access completes in its first cycle.
    assign ready = (MEM_HS != 0) ? mem_ready : 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_legal(opcode))  state_d = S_EXECUTE;
                else if (TRAP_EN != 0) state_d = S_TRAP;
                else                   state_d = S_FETCH;
            end
            S_EXECUTE: begin
                if (opcode == OP_BRANCH)                          state_d = S_FETCH;
                else if (opcode == OP_LOAD || opcode == OP_STORE) state_d = S_MEM;
                else                                              state_d = S_WB;
            end
            S_MEM: begin
                if (ready) state_d = (opcode == OP_LOAD) ? S_WB : S_FETCH;
            end
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        instr_read  = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_src_imm = 1'b0;
        wb_sel      = 2'b00;
        pc_sel      = 1'b0;
        case (state_q)
            S_FETCH:  instr_read = 1'b1;
            S_DECODE: pc_write = !is_legal(opcode) && (TRAP_EN == 0);
            S_EXECUTE: begin
                alu_src_imm = !(opcode == OP_R || opcode == OP_BRANCH);
                if (opcode == OP_BRANCH) begin
                    pc_write = 1'b1;
                    pc_sel   = branch_taken;
                end
            end
            S_MEM: begin
                alu_src_imm = !(opcode == OP_R || opcode == OP_BRANCH);
                mem_read    = (opcode == OP_LOAD);
                mem_write   = (opcode == OP_STORE);
                pc_write    = ready && (opcode == OP_STORE);
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_sel    = (opcode == OP_JAL);
                wb_sel    = wb_of(opcode);
            end
            default: ;
        endcase
        // No write may escape during a reset cycle, whatever the state register holds.
        if (rst) begin
            instr_read = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pc_write)          retired_q <= retired_q + CNT_W'(1);
            if (state_d == S_TRAP) illegal_q <= 1'b1;
        end
    end

    assign illegal_insn = illegal_q;
    assign state        = state_q;
    assign retired      = retired_q;

endmodule
